// File: rtl/rca_multiword_sequencer_pkg.sv
// Shared definitions for the multi-nibble ripple-carry sequencer.
// Contents:
//   - NIB_W   : width of one adder slice.
//   - state_t : controller state encoding (IDLE/RUN/DONE, 2 bits).
//   - OP_ADD / OP_SUB : values of the cmd_sub operation select.
package rca_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_multiword_sequencer_if.sv
// Command/result handshake bundle for rca_multiword_sequencer.
// Command side : cmd_valid, cmd_ready, cmd_sub, cmd_a, cmd_b, cmd_cin.
// Result side  : res_valid, res_ready, res_sum, res_cout, res_ovf.
// Modports:
//   master - upstream issuer / downstream consumer (the environment).
//   slave  - the sequencer itself.
interface rca_multiword_sequencer_if
  import rca_pkg::*;
#(
  parameter int NUM_NIB = 4
);

  localparam int W = NIB_W * NUM_NIB;

  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_sub;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_cin;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;

  modport master (
    output cmd_valid, cmd_sub, cmd_a, cmd_b, cmd_cin, res_ready,
    input  cmd_ready, res_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_sub, cmd_a, cmd_b, cmd_cin, res_ready,
    output cmd_ready, res_valid, res_sum, res_cout, res_ovf
  );

endinterface

// File: rtl/rca_multiword_sequencer.sv
// Multi-nibble add/subtract sequencer around an external 4-bit ripple-carry
// adder. Wide operands are processed one nibble per clock, LSB first, with the
// adder carry-out fed back through an internal carry register.
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset.
//   bus (slave)      - command and result valid/ready handshakes.
//   rca_a/rca_b      - nibble operands to the adder (rca_b pre-inverted for
//                      subtract); rca_cin carry into the adder.
//   rca_op/rca_cout  - adder sum and carry-out, sampled the same cycle.
//   busy             - high while an operation is in RUN or DONE.
module rca_multiword_sequencer
  import rca_pkg::*;
#(
  parameter int NUM_NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rca_multiword_sequencer_if.slave bus,
  output logic [NIB_W-1:0] rca_a,
  output logic [NIB_W-1:0] rca_b,
  output logic             rca_cin,
  input  logic [NIB_W-1:0] rca_op,
  input  logic             rca_cout,
  output logic             busy
);

  localparam int W     = NIB_W * NUM_NIB;
  localparam int IDX_W = $clog2(NUM_NIB);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [W-1:0]       sum_d;
  logic [W-1:0]       res_sum_q;
  logic               res_cout_q;
  logic               res_ovf_q;
  logic               res_valid_q;
  logic               busy_q;
  logic               last_nib;
  logic               ovf_d;

  always_comb begin
    sum_d = sum_q;
    sum_d[NIB_W*int'(idx_q) +: NIB_W] = rca_op;
    last_nib = (idx_q == IDX_W'(NUM_NIB - 1));
    // b_q already holds ~B for subtract, so one rule covers add and subtract.
    ovf_d = (a_q[W-1] == b_q[W-1]) && (rca_op[NIB_W-1] != a_q[W-1]);

    rca_a   = '0;
    rca_b   = '0;
    rca_cin = 1'b0;
    if (state_q == ST_RUN) begin
      rca_a   = a_q[NIB_W*int'(idx_q) +: NIB_W];
      rca_b   = b_q[NIB_W*int'(idx_q) +: NIB_W];
      rca_cin = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            a_q     <= bus.cmd_a;
            b_q     <= (bus.cmd_sub == OP_SUB) ? ~bus.cmd_b : bus.cmd_b;
            // Subtract: A + ~B + 1 - borrow_in, hence the inverted carry.
            carry_q <= bus.cmd_cin ^ bus.cmd_sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= rca_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) begin
            // Published results live in their own registers so they stay
            // put while the next command rebuilds sum_q.
            res_sum_q   <= sum_d;
            res_cout_q  <= rca_cout;
            res_ovf_q   <= ovf_d;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Directed bench for rca_multiword_sequencer with NUM_NIB = 4 and a
// behavioural 4-bit adder standing in for the shared ripple-carry adder.
module tb_rca_multiword_sequencer;
  import rca_pkg::*;

  localparam int NUM_NIB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rca_a, rca_b, rca_op;
  logic       rca_cin, rca_cout, busy;

  int errors = 0;
  int checks = 0;

  rca_multiword_sequencer_if #(.NUM_NIB(NUM_NIB)) bus ();

  rca_multiword_sequencer #(.NUM_NIB(NUM_NIB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .rca_a    (rca_a),
    .rca_b    (rca_b),
    .rca_cin  (rca_cin),
    .rca_op   (rca_op),
    .rca_cout (rca_cout),
    .busy     (busy)
  );

  assign {rca_cout, rca_op} = 5'(rca_a) + 5'(rca_b) + 5'(rca_cin);

  always #5 clk = ~clk;

  task automatic issue(input logic sub, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    bus.cmd_sub   = sub;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cin   = cin;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sub   = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_cin   = 1'b0;
    bus.res_ready = 1'b1;
    #2;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== 18'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", {bus.res_sum, bus.res_cout, bus.res_ovf}); end
    checks++; if ({rca_a, rca_b, rca_cin} !== 9'h0) begin errors++; $display("FAIL reset_rca: got %h expected 0", {rca_a, rca_b, rca_cin}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    int cyc, lat, nb;
    issue(OP_ADD, 16'h1234, 16'h0FFF, 1'b0);
    cyc = 0; lat = -1; nb = 0;
    while (busy && cyc < 50) begin
      nb++;
      if (bus.res_valid && lat < 0) lat = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++; if (nb !== 5) begin errors++; $display("FAIL add_busy_span: got %0d expected 5", nb); end
    checks++; if (bus.res_sum !== 16'h2233) begin errors++; $display("FAIL add_sum: got %h expected 2233", bus.res_sum); end
    checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {bus.res_cout, bus.res_ovf}); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_add_carry();
    int lat;
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    checks++; if (rca_cin !== 1'b0) begin errors++; $display("FAIL carry_cin_nib0: got %b expected 0", rca_cin); end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (rca_cin !== 1'b1) begin errors++; $display("FAIL carry_cin_nib%0d: got %b expected 1", k, rca_cin); end
    end
    wait_res(lat);
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h expected 0000", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b expected 1", bus.res_cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [15:0] va [2] = '{16'h0005, 16'h0007};
    logic [15:0] vb [2] = '{16'h0007, 16'h0005};
    logic        vc [2] = '{1'b0, 1'b1};
    logic [15:0] es [2] = '{16'hFFFE, 16'h0001};
    logic        ec [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(OP_SUB, va[i], vb[i], vc[i]);
      wait_res(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL sub%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (bus.res_sum !== es[i]) begin errors++; $display("FAIL sub%0d_sum: got %h expected %h", i, bus.res_sum, es[i]); end
      checks++; if (bus.res_cout !== ec[i]) begin errors++; $display("FAIL sub%0d_cout: got %b expected %b", i, bus.res_cout, ec[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ovf();
    logic        vs [2] = '{OP_ADD, OP_SUB};
    logic [15:0] va [2] = '{16'h7FFF, 16'h8000};
    logic [15:0] es [2] = '{16'h8000, 16'h7FFF};
    logic        ec [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(vs[i], va[i], 16'h0001, 1'b0);
      wait_res(lat);
      checks++; if (bus.res_sum !== es[i]) begin errors++; $display("FAIL ovf%0d_sum: got %h expected %h", i, bus.res_sum, es[i]); end
      checks++; if (bus.res_ovf !== 1'b1) begin errors++; $display("FAIL ovf%0d_flag: got %b expected 1", i, bus.res_ovf); end
      checks++; if (bus.res_cout !== ec[i]) begin errors++; $display("FAIL ovf%0d_cout: got %b expected %b", i, bus.res_cout, ec[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, lat;
    logic [15:0] got_sum;
    bus.cmd_sub = OP_ADD; bus.cmd_a = 16'h0F0F; bus.cmd_b = 16'h0101; bus.cmd_cin = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0; got_sum = 16'hDEAD;
    while (!bus.cmd_ready && cyc < 50) begin
      if (bus.res_valid) got_sum = bus.res_sum;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_ready_gap: got %0d expected 5", cyc); end
    checks++; if (got_sum !== 16'h1010) begin errors++; $display("FAIL b2b_sum0: got %h expected 1010", got_sum); end
    bus.cmd_a = 16'h2000; bus.cmd_b = 16'h0003;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL b2b_accept: got %b expected 01", {bus.cmd_ready, busy}); end
    wait_res(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (bus.res_sum !== 16'h2003) begin errors++; $display("FAIL b2b_sum1: got %h expected 2003", bus.res_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.res_ready = 1'b0;
    issue(OP_ADD, 16'h1111, 16'h2222, 1'b0);
    wait_res(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b expected 1", k, bus.res_valid); end
      checks++; if (bus.res_sum !== 16'h3333) begin errors++; $display("FAIL bp_sum_c%0d: got %h expected 3333", k, bus.res_sum); end
      checks++; if (bus.res_cout !== 1'b0) begin errors++; $display("FAIL bp_cout_c%0d: got %b expected 0", k, bus.res_cout); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready_c%0d: got %b expected 0", k, bus.cmd_ready); end
      bus.cmd_valid = (k == 2);
      bus.cmd_a = 16'hAAAA; bus.cmd_b = 16'h5555;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.res_valid, bus.cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL bp_release: got %b expected 010", {bus.res_valid, bus.cmd_ready, busy}); end
    checks++; if (bus.res_sum !== 16'h3333) begin errors++; $display("FAIL bp_hold_after: got %h expected 3333", bus.res_sum); end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen;
    issue(OP_ADD, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rca_a !== 4'h2) begin errors++; $display("FAIL rst_pre_nib2: got %h expected 2", rca_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.cmd_ready, busy, bus.res_valid} !== 3'b100) begin errors++; $display("FAIL rst_abort_ctrl: got %b expected 100", {bus.cmd_ready, busy, bus.res_valid}); end
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL rst_abort_sum: got %h expected 0000", bus.res_sum); end
    checks++; if (rca_a !== 4'h0) begin errors++; $display("FAIL rst_abort_rca: got %h expected 0", rca_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.res_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_valid: got %0d expected 0", seen); end
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b0);
    wait_res(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_next_latency: got %0d expected 4", lat); end
    checks++; if (bus.res_sum !== 16'h0002) begin errors++; $display("FAIL rst_next_sum: got %h expected 0002", bus.res_sum); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
